// File: rtl/dmux_scan_capture.sv
// rtl/dmux_scan_capture.sv - scan an 8:1 bit-select stage and assemble the sampled bits into a byte
// Ports: clk, rst_n (async, active low); start/first_sel/num_bits/dir scan request;
// mux_sel/mux_out select and returned bit of the bit-select stage;
// data_out/data_valid/data_ready result handshake; busy high outside IDLE.
module dmux_scan_capture #(
  parameter int SETTLE = 1,
  parameter int NUM_CH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [$clog2(NUM_CH)-1:0] first_sel,
  input  logic [3:0]                num_bits,
  input  logic                      dir,
  output logic [$clog2(NUM_CH)-1:0] mux_sel,
  input  logic                      mux_out,
  output logic [NUM_CH-1:0]         data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      busy
);

  localparam int         SEL_W     = $clog2(NUM_CH);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [3:0] MAX_BITS  = 4'(NUM_CH);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t     state;
  logic [3:0] settle_cnt;
  logic [3:0] k;
  logic [3:0] n;
  logic       dir_q;
  logic [3:0] num_eff;

  // A length of 0 or anything beyond the channel count means a full scan.
  always_comb begin
    num_eff = num_bits;
    if (num_bits == 4'd0 || num_bits > MAX_BITS) num_eff = MAX_BITS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mux_sel    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      settle_cnt <= 4'd0;
      k          <= 4'd0;
      n          <= 4'd0;
      dir_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SCAN;
            busy       <= 1'b1;
            n          <= num_eff;
            dir_q      <= dir;
            mux_sel    <= first_sel;
            data_out   <= '0;
            settle_cnt <= 4'd0;
            k          <= 4'd0;
          end
        end
        SCAN: begin
          if (settle_cnt < SETTLE_M1) begin
            settle_cnt <= settle_cnt + 4'd1;
          end else begin
            // Sample edge: capture, then move the select on so the next
            // channel gets its full settle window.
            data_out[k[SEL_W-1:0]] <= mux_out;
            k          <= k + 4'd1;
            settle_cnt <= 4'd0;
            mux_sel    <= dir_q ? mux_sel - SEL_W'(1) : mux_sel + SEL_W'(1);
            if (k == n - 4'd1) begin
              state      <= HOLD;
              data_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (data_valid && data_ready) begin
            data_valid <= 1'b0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmux_scan_capture.sv
// tb/tb_dmux_scan_capture.sv - randomized self-checking bench for dmux_scan_capture
module tb_dmux_scan_capture;

  logic       clk;
  logic       rst_n;
  logic       start_a      [2];
  logic [2:0] first_sel_a  [2];
  logic [3:0] num_bits_a   [2];
  logic       dir_a        [2];
  logic [2:0] mux_sel_a    [2];
  logic       mux_out_a    [2];
  logic [7:0] data_out_a   [2];
  logic       data_valid_a [2];
  logic       data_ready_a [2];
  logic       busy_a       [2];
  logic [7:0] mux_vec      [2];

  int total = 0;
  int bad   = 0;

  // Instance 0 uses SETTLE=1, instance 1 uses SETTLE=3.
  dmux_scan_capture #(.SETTLE(1), .NUM_CH(8)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .first_sel(first_sel_a[0]),
    .num_bits(num_bits_a[0]), .dir(dir_a[0]), .mux_sel(mux_sel_a[0]),
    .mux_out(mux_out_a[0]), .data_out(data_out_a[0]), .data_valid(data_valid_a[0]),
    .data_ready(data_ready_a[0]), .busy(busy_a[0])
  );

  dmux_scan_capture #(.SETTLE(3), .NUM_CH(8)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .first_sel(first_sel_a[1]),
    .num_bits(num_bits_a[1]), .dir(dir_a[1]), .mux_sel(mux_sel_a[1]),
    .mux_out(mux_out_a[1]), .data_out(data_out_a[1]), .data_valid(data_valid_a[1]),
    .data_ready(data_ready_a[1]), .busy(busy_a[1])
  );

  // Behavioural 8:1 bit-select stage feeding each instance.
  assign mux_out_a[0] = mux_vec[0][mux_sel_a[0]];
  assign mux_out_a[1] = mux_vec[1][mux_sel_a[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int eff_len(input int nb);
    return (nb == 0 || nb > 8) ? 8 : nb;
  endfunction

  // Channel visited by the i-th sample of a scan.
  function automatic int chan(input int first, input int dir, input int i);
    return dir ? ((first - i + 64) % 8) : ((first + i) % 8);
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] vec, input int first,
                                            input int nb, input int dir);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < eff_len(nb); i++) r[i] = vec[chan(first, dir, i)];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one scan and follow it edge by edge up to data_valid.
  task automatic do_scan(input int d, input logic [7:0] vec, input int first,
                         input int nb, input int dir, input string tag);
    int n;
    int s;
    logic [2:0] exp_sel;
    logic [7:0] exp_byte;
    n = eff_len(nb);
    s = settle_of(d);
    exp_byte = model_byte(vec, first, nb, dir);
    mux_vec[d]     = vec;
    first_sel_a[d] = 3'(first);
    num_bits_a[d]  = 4'(nb);
    dir_a[d]       = dir[0];
    start_a[d]     = 1'b1;
    tick();
    start_a[d] = 1'b0;
    // Scrambling the request inputs mid-scan must have no effect.
    first_sel_a[d] = 3'($urandom_range(7));
    num_bits_a[d]  = 4'($urandom_range(15));
    dir_a[d]       = 1'($urandom_range(1));
    for (int c = 0; c < n * s; c++) begin
      exp_sel = 3'(chan(first, dir, c / s));
      total++;
      if (mux_sel_a[d] !== exp_sel || data_valid_a[d] !== 1'b0 || busy_a[d] !== 1'b1) begin
        bad++;
        $display("FAIL %s scan_step c=%0d: sel=%0d valid=%0b busy=%0b, want sel=%0d valid=0 busy=1",
                 tag, c, mux_sel_a[d], data_valid_a[d], busy_a[d], exp_sel);
      end
      tick();
    end
    total++;
    if (data_valid_a[d] !== 1'b1 || data_out_a[d] !== exp_byte || busy_a[d] !== 1'b1 ||
        mux_sel_a[d] !== 3'(chan(first, dir, n))) begin
      bad++;
      $display("FAIL %s result: valid=%0b data=%02h busy=%0b sel=%0d, want valid=1 data=%02h busy=1 sel=%0d",
               tag, data_valid_a[d], data_out_a[d], busy_a[d], mux_sel_a[d], exp_byte,
               chan(first, dir, n));
    end
  endtask

  // Hold off for 'stall' cycles, then complete the handshake.
  task automatic do_drain(input int d, input int stall, input string tag);
    logic [7:0] held;
    logic [2:0] sel;
    held = data_out_a[d];
    sel  = mux_sel_a[d];
    data_ready_a[d] = 1'b0;
    for (int i = 0; i < stall; i++) begin
      start_a[d]     = 1'b1;
      first_sel_a[d] = 3'($urandom_range(7));
      mux_vec[d]     = 8'($urandom);
      tick();
      total++;
      if (data_valid_a[d] !== 1'b1 || data_out_a[d] !== held || busy_a[d] !== 1'b1 ||
          mux_sel_a[d] !== sel) begin
        bad++;
        $display("FAIL %s hold_stable i=%0d: valid=%0b data=%02h busy=%0b sel=%0d, want 1/%02h/1/%0d",
                 tag, i, data_valid_a[d], data_out_a[d], busy_a[d], mux_sel_a[d], held, sel);
      end
    end
    start_a[d] = 1'b0;
    data_ready_a[d] = 1'b1;
    tick();
    data_ready_a[d] = 1'b0;
    total++;
    if (data_valid_a[d] !== 1'b0 || busy_a[d] !== 1'b0 || data_out_a[d] !== held) begin
      bad++;
      $display("FAIL %s handshake: valid=%0b busy=%0b data=%02h, want 0/0/%02h",
               tag, data_valid_a[d], busy_a[d], data_out_a[d], held);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_a[d] = 1'b0; first_sel_a[d] = 3'd0; num_bits_a[d] = 4'd0;
      dir_a[d] = 1'b0; data_ready_a[d] = 1'b0; mux_vec[d] = 8'h00;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (mux_sel_a[d] !== 3'd0 || data_out_a[d] !== 8'h00 || data_valid_a[d] !== 1'b0 ||
          busy_a[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state d=%0d: sel=%0d data=%02h valid=%0b busy=%0b, want all 0",
                 d, mux_sel_a[d], data_out_a[d], data_valid_a[d], busy_a[d]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_plan_vectors();
    do_scan(0, 8'hA5, 0, 8, 0, "a5_inc");
    total++;
    if (data_out_a[0] !== 8'hA5) begin
      bad++;
      $display("FAIL a5_const: data=%02h, want a5", data_out_a[0]);
    end
    do_drain(0, 0, "a5_inc");
    do_scan(0, 8'h1E, 7, 0, 1, "1e_dec");
    total++;
    if (data_out_a[0] !== 8'h78) begin
      bad++;
      $display("FAIL 1e_const: data=%02h, want 78", data_out_a[0]);
    end
    do_drain(0, 0, "1e_dec");
    do_scan(0, 8'h41, 6, 4, 0, "41_wrap");
    total++;
    if (data_out_a[0] !== 8'h05) begin
      bad++;
      $display("FAIL 41_const: data=%02h, want 05", data_out_a[0]);
    end
    do_drain(0, 0, "41_wrap");
  endtask

  task automatic test_settle3();
    do_scan(1, 8'hFF, 0, 2, 0, "ff_settle3");
    total++;
    if (data_out_a[1] !== 8'h03) begin
      bad++;
      $display("FAIL ff_settle3_const: data=%02h, want 03", data_out_a[1]);
    end
    do_drain(1, 0, "ff_settle3");
  endtask

  task automatic test_backpressure();
    do_scan(0, 8'h3C, 2, 5, 1, "bp");
    do_drain(0, 5, "bp");
  endtask

  // A start presented on the handshake edge is dropped; the next cycle takes it.
  task automatic test_back_to_back();
    do_scan(0, 8'h96, 1, 3, 0, "b2b_a");
    data_ready_a[0] = 1'b1;
    start_a[0]      = 1'b1;
    first_sel_a[0]  = 3'd5;
    tick();
    data_ready_a[0] = 1'b0;
    start_a[0]      = 1'b0;
    total++;
    if (busy_a[0] !== 1'b0 || data_valid_a[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_start_on_handshake: busy=%0b valid=%0b, want 0/0",
               busy_a[0], data_valid_a[0]);
    end
    do_scan(0, 8'h5A, 5, 8, 1, "b2b_b");
    do_drain(0, 1, "b2b_b");
  endtask

  task automatic test_reset_mid_scan();
    mux_vec[0]     = 8'hFF;
    first_sel_a[0] = 3'd0;
    num_bits_a[0]  = 4'd8;
    dir_a[0]       = 1'b0;
    start_a[0]     = 1'b1;
    tick();
    start_a[0] = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (mux_sel_a[0] !== 3'd0 || data_out_a[0] !== 8'h00 || data_valid_a[0] !== 1'b0 ||
        busy_a[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_scan: sel=%0d data=%02h valid=%0b busy=%0b, want all 0",
               mux_sel_a[0], data_out_a[0], data_valid_a[0], busy_a[0]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_scan(0, 8'hC3, 3, 8, 0, "after_reset");
    do_drain(0, 2, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int d;
      d = it % 2;
      do_scan(d, 8'($urandom), int'($urandom_range(7)), int'($urandom_range(15)),
              int'($urandom_range(1)), "rand");
      do_drain(d, int'($urandom_range(3)), "rand");
      if ($urandom_range(1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_settle3();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
